aes_modified_enc: RTL and testbench

Iterative AES-128 encryption core (FIPS-197 cipher, encrypt only) that computes one round per clock cycle with on-the-fly key expansion. It sits between a block-level controller, which presents a 128-bit plaintext and key and pulses `start`, and downstream logic that reads the registered ciphertext on `out`. Plaintext, key and ciphertext use a row-major byte layout rather than the FIPS column-major byte stream.

---
 rtl/aes_modified_enc.sv | 174 +++++++++++++++++
 tb/tb_aes_modified_enc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_modified_enc.sv
// Iterative AES-128 encryption core, one round per clock, on-the-fly key expansion.
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous active-low reset
//   start     - begin one encryption (ignored while busy)
//   in        - 128-bit plaintext, row-major: s(r,c) at [127-8*(4r+c) -: 8]
//   encrypkey - 128-bit cipher key, same layout
//   out       - registered ciphertext, valid 10 cycles after the accepted start
module aes_modified_enc (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] encrypkey,
    output logic [127:0] out
);

    localparam int unsigned BW = 128;
    localparam int unsigned RW = 4;
    localparam int unsigned NR = 10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row-major byte accessor: s(r,c)
    function automatic logic [7:0] get_byte(input logic [BW-1:0] s, input int unsigned r,
                                            input int unsigned c);
        return s[BW-1-8*(RW*r+c) -: 8];
    endfunction

    // SubBytes followed by ShiftRows: s'(r,c) = S(s(r, (c+r) mod 4))
    function automatic logic [BW-1:0] sub_shift(input logic [BW-1:0] s);
        logic [BW-1:0] o;
        o = '0;
        for (int unsigned r = 0; r < RW; r++)
            for (int unsigned c = 0; c < RW; c++)
                o[BW-1-8*(RW*r+c) -: 8] = sbox(get_byte(s, r, (c + r) % RW));
        return o;
    endfunction

    function automatic logic [BW-1:0] mix_columns(input logic [BW-1:0] s);
        logic [BW-1:0] o;
        logic [7:0]    a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < RW; c++) begin
            a0 = get_byte(s, 0, c);
            a1 = get_byte(s, 1, c);
            a2 = get_byte(s, 2, c);
            a3 = get_byte(s, 3, c);
            o[BW-1-8*c  -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[BW-33-8*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[BW-65-8*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[BW-97-8*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // One key-schedule step; each key column is one schedule word, row 0 is the MSB byte
    function automatic logic [BW-1:0] next_key(input logic [BW-1:0] k, input logic [7:0] rc);
        logic [31:0]   w [RW];
        logic [31:0]   t;
        logic [BW-1:0] o;
        for (int unsigned c = 0; c < RW; c++)
            w[c] = {get_byte(k, 0, c), get_byte(k, 1, c), get_byte(k, 2, c), get_byte(k, 3, c)};
        t = {sbox(w[3][23:16]) ^ rc, sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])};
        w[0] = w[0] ^ t;
        for (int unsigned c = 1; c < RW; c++)
            w[c] = w[c] ^ w[c-1];
        o = '0;
        for (int unsigned c = 0; c < RW; c++)
            for (int unsigned r = 0; r < RW; r++)
                o[BW-1-8*(RW*r+c) -: 8] = w[c][31-8*r -: 8];
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [BW-1:0] state_q, state_d;
    logic [BW-1:0] key_q, key_d;
    logic [BW-1:0] out_q, out_d;
    logic [3:0]    round_q, round_d;
    logic          busy_q, busy_d;

    logic [BW-1:0] round_key_c;
    logic [BW-1:0] sub_shift_c;

    assign round_key_c = next_key(key_q, rcon(round_q));
    assign sub_shift_c = sub_shift(state_q);

    // Next-state: accept start when idle, otherwise advance one round
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        out_d   = out_q;
        round_d = round_q;
        busy_d  = busy_q;
        if (!busy_q) begin
            if (start) begin
                state_d = in ^ encrypkey;
                key_d   = encrypkey;
                round_d = 4'd1;
                busy_d  = 1'b1;
            end
        end else begin
            key_d = round_key_c;
            if (round_q == 4'(NR)) begin
                state_d = sub_shift_c ^ round_key_c;
                out_d   = sub_shift_c ^ round_key_c;
                round_d = 4'd0;
                busy_d  = 1'b0;
            end else begin
                state_d = mix_columns(sub_shift_c) ^ round_key_c;
                round_d = round_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
            key_q   <= '0;
            out_q   <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            out_q   <= out_d;
            round_q <= round_d;
            busy_q  <= busy_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_aes_modified_enc.sv
// Self-checking bench for aes_modified_enc: FIPS vectors, timing boundaries,
// reset abort, back-to-back starts, and random blocks against a byte-level model.
module tb_aes_modified_enc;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] pt_in;
    logic [127:0] key_in;
    logic [127:0] out_w;

    int checks;
    int failures;
    logic [127:0] prev_out;
    logic [7:0]   sbx [256];

    localparam logic [127:0] B_PT  = 128'h328831e0_435a3137_f6309807_a88da234;
    localparam logic [127:0] B_KEY = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
    localparam logic [127:0] B_CT  = 128'h3902dc19_25dc116a_8409850b_1dfb9732;
    localparam logic [127:0] C_PT  = 128'h004488cc_115599dd_2266aaee_3377bbff;
    localparam logic [127:0] C_KEY = 128'h0004080c_0105090d_02060a0e_03070b0f;
    localparam logic [127:0] C_CT  = 128'h696ad870_c47bcdb4_e004b7c5_d830805a;
    localparam logic [127:0] Z_CT  = 128'h66ef88ca_e98a4c34_4b2cfa2b_d43b592e;

    aes_modified_enc dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in        (pt_in),
        .encrypkey (key_in),
        .out       (out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse in GF(2^8) then the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            end
            sbx[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Reference AES-128 on a 4x4 byte matrix with an expanded 44-word schedule
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] w [44][4];
        logic [7:0] tmp [4];
        logic [7:0] rc;
        logic [7:0] acc;
        logic [7:0] coef [4];
        logic [127:0] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s[r][c] = pt[127-8*(4*r+c) -: 8];
                w[c][r] = key[127-8*(4*r+c) -: 8];
            end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp[0] = sbx[w[i-1][1]] ^ rc;
                tmp[1] = sbx[w[i-1][2]];
                tmp[2] = sbx[w[i-1][3]];
                tmp[3] = sbx[w[i-1][0]];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[c][r];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sbx[s[r][(c + r) % 4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd < 10) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - r + 4) % 4], t[j][c]);
                    end else begin
                        acc = t[r][c];
                    end
                    s[r][c] = acc ^ w[4*rnd+c][r];
                end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) res[127-8*(4*r+c) -: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Entered at a negedge; start sampled at E0; optional extra start pulse at edge E_poke
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] expv, input int poke, input string tag);
        start  = 1'b1;
        pt_in  = pt;
        key_in = key;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        pt_in  = rand128();
        key_in = rand128();
        for (int k = 1; k <= 10; k++) begin
            if (k == poke) begin
                start  = 1'b1;
                pt_in  = '0;
                key_in = '0;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (k < 10) check({tag, "_hold"}, out_w, prev_out);
            else        check({tag, "_ct"}, out_w, expv);
        end
        prev_out = expv;
    endtask

    task automatic idle_hold(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check(tag, out_w, prev_out);
        end
    endtask

    initial begin
        logic [127:0] rp, rk, rexp;
        checks   = 0;
        failures = 0;
        prev_out = '0;
        rst      = 1'b0;
        start    = 1'b0;
        pt_in    = '0;
        key_in   = '0;
        build_sbox();

        // Reset state, and start ignored while reset is held
        @(negedge clk);
        check("reset_out", out_w, 128'h0);
        start = 1'b1;
        pt_in = B_PT;
        key_in = B_KEY;
        repeat (3) @(negedge clk);
        check("reset_start_ignored", out_w, 128'h0);
        start = 1'b0;
        rst   = 1'b1;

        // App. B with a start pulse at E5 that must be ignored
        run_block(B_PT, B_KEY, B_CT, 5, "fips_b");
        idle_hold(12, "fips_b_after");

        // App. C.1 with a start pulse at E10 (busy still set at that edge)
        run_block(C_PT, C_KEY, C_CT, 10, "fips_c1");
        idle_hold(12, "fips_c1_after");

        run_block(128'h0, 128'h0, Z_CT, 0, "all_zero");

        for (int n = 0; n < 6; n++) begin
            rp   = rand128();
            rk   = rand128();
            rexp = aes_ref(rp, rk);
            run_block(rp, rk, rexp, 0, $sformatf("rand%0d", n));
        end

        // Asynchronous reset in the middle of a block
        start  = 1'b1;
        pt_in  = rand128();
        key_in = rand128();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst_async_out", out_w, 128'h0);
        @(negedge clk);
        check("rst_held_out", out_w, 128'h0);
        rst      = 1'b1;
        prev_out = '0;
        run_block(C_PT, C_KEY, C_CT, 0, "after_rst");

        // Back-to-back: start held high, inputs switched to C.1 after E0
        start  = 1'b1;
        pt_in  = B_PT;
        key_in = B_KEY;
        @(posedge clk);
        @(negedge clk);
        pt_in  = C_PT;
        key_in = C_KEY;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 11) start = 1'b0;
            if (k < 10)       check("b2b_first_hold", out_w, prev_out);
            else if (k < 21)  check("b2b_first_ct", out_w, B_CT);
            else              check("b2b_second_ct", out_w, C_CT);
        end
        prev_out = C_CT;
        idle_hold(4, "b2b_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
